// File: rtl/yuv2rgb_pkg.sv
// Shared constants, state encoding and clamp helper for the YUV->RGB converter.
package yuv2rgb_pkg;

    localparam int W_IN  = 9;
    localparam int W_ACC = 19;

    // BT.601 full-range coefficients in Q8
    localparam logic [8:0] CRV = 9'd359;
    localparam logic [8:0] CGU = 9'd88;
    localparam logic [8:0] CGV = 9'd183;
    localparam logic [8:0] CBU = 9'd454;

    localparam logic [8:0]              OFFSET = 9'd128;
    localparam logic signed [W_ACC-1:0] ROUND  = W_ACC'(128);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Takes the rounded Q8 sum, drops the fraction (floor) and saturates to 0..255.
    // The sign bit flags a negative result; any set bit above bit 15 means > 255.
    function automatic logic [7:0] clamp8(input logic signed [W_ACC-1:0] s);
        if (s[W_ACC-1])
            return 8'd0;
        else if (|s[W_ACC-2:16])
            return 8'd255;
        else
            return s[15:8];
    endfunction

endpackage

// File: rtl/yuv2rgb_if.sv
// Pixel handshake bundle: start/done plus the Y/U/V inputs and R/G/B results.
interface yuv2rgb_if;
    import yuv2rgb_pkg::*;

    logic            start;
    logic [W_IN-1:0] inY;
    logic [W_IN-1:0] inU;
    logic [W_IN-1:0] inV;
    logic            done;
    logic [W_IN-1:0] outR;
    logic [W_IN-1:0] outG;
    logic [W_IN-1:0] outB;

    modport master (output start, inY, inU, inV, input done, outR, outG, outB);
    modport slave  (input start, inY, inU, inV, output done, outR, outG, outB);
endinterface

// File: rtl/yuv_mul_sa.sv
// One serial shift-add multiplier lane: acc = coeff * d, one coefficient bit per step.
module yuv_mul_sa
    import yuv2rgb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    step,
    input  logic [3:0]              k,
    input  logic [8:0]              coeff,
    input  logic signed [8:0]       d,
    output logic signed [W_ACC-1:0] acc
);

    logic signed [W_ACC-1:0] d_ext;
    logic signed [W_ACC-1:0] addend;

    // Partial product for bit k: sign-extended operand shifted into place, or nothing.
    always_comb begin
        d_ext  = {{(W_ACC-9){d[8]}}, d};
        addend = coeff[k] ? (d_ext <<< k) : '0;
    end

    // Accumulate one partial product per step; clr restarts the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (step)
            acc <= acc + addend;
    end

endmodule

// File: rtl/yuv2rgb.sv
// YUV -> RGB converter: captures a pixel, runs four serial multiplier lanes
// for nine cycles, then rounds, clamps and registers R/G/B with a done pulse.
//
//   state | meaning
//   IDLE  | wait for start; capture Y and the offset U/V, clear lanes
//   MUL   | one coefficient bit per cycle, cnt 0..8
//   SUM   | round, clamp and register outputs, raise done
//   DONE  | drop done, return to IDLE (keeps the 12-clock pixel slot)
module yuv2rgb
    import yuv2rgb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    yuv2rgb_if.slave  bus
);

    state_t                  state, state_n;
    logic [3:0]              cnt;
    logic [7:0]              y_q;
    logic signed [8:0]       du_q, dv_q;
    logic                    clr, step;
    logic signed [W_ACC-1:0] acc_rv, acc_gu, acc_gv, acc_bu;
    logic signed [W_ACC-1:0] y_term, r_sum, g_sum, b_sum;
    logic [W_IN-1:0]         r_q, g_q, b_q;
    logic                    done_q;
    logic                    unused_bit8;

    // Bit 8 of the pixel inputs carries no information.
    assign unused_bit8 = ^{bus.inY[8], bus.inU[8], bus.inV[8]};

    yuv_mul_sa u_lane_rv (.clk(clk), .rst(rst), .clr(clr), .step(step), .k(cnt),
                          .coeff(CRV), .d(dv_q), .acc(acc_rv));
    yuv_mul_sa u_lane_gu (.clk(clk), .rst(rst), .clr(clr), .step(step), .k(cnt),
                          .coeff(CGU), .d(du_q), .acc(acc_gu));
    yuv_mul_sa u_lane_gv (.clk(clk), .rst(rst), .clr(clr), .step(step), .k(cnt),
                          .coeff(CGV), .d(dv_q), .acc(acc_gv));
    yuv_mul_sa u_lane_bu (.clk(clk), .rst(rst), .clr(clr), .step(step), .k(cnt),
                          .coeff(CBU), .d(du_q), .acc(acc_bu));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state and lane control; start only matters in IDLE.
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_n = MUL;
                end
            end
            MUL: begin
                step = 1'b1;
                if (cnt == 4'd8)
                    state_n = SUM;
            end
            SUM:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Q8 sums with rounding constant; products come straight from the lanes.
    always_comb begin
        y_term = {{(W_ACC-16){1'b0}}, y_q, 8'd0};
        r_sum  = y_term + acc_rv + ROUND;
        g_sum  = y_term - acc_gu - acc_gv + ROUND;
        b_sum  = y_term + acc_bu + ROUND;
    end

    // Capture, bit counter, output registers and the one-cycle done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            du_q   <= '0;
            dv_q   <= '0;
            cnt    <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE && bus.start) begin
                y_q  <= bus.inY[7:0];
                du_q <= {1'b0, bus.inU[7:0]} - OFFSET;
                dv_q <= {1'b0, bus.inV[7:0]} - OFFSET;
                cnt  <= '0;
            end else if (state == MUL) begin
                cnt <= cnt + 4'd1;
            end
            if (state == SUM) begin
                r_q    <= {1'b0, clamp8(r_sum)};
                g_q    <= {1'b0, clamp8(g_sum)};
                b_q    <= {1'b0, clamp8(b_sum)};
                done_q <= 1'b1;
            end
        end
    end

    assign bus.done = done_q;
    assign bus.outR = r_q;
    assign bus.outG = g_q;
    assign bus.outB = b_q;

endmodule
